// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like split-handshake port between instruction
// fetch and data access, data side first; one outstanding transaction at a time.
// Latency: 3 cycles minimum from request to ready pulse. Backpressure: requests wait in
// IDLE arbitration, and the FSM holds without limit on addr_ok/data_ok wait states.
// Ports: clk/rst; inst_* fetch side; data_* load/store side; mem_* memory bus.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_ready,
  output logic              inst_stall,
  // data side
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic              data_stall,
  // memory bus
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t state;
  logic   owner;     // 0 = inst, 1 = data

  // Stalls are the only combinational outputs; they must drop in the ready cycle.
  assign inst_stall = inst_req & ~inst_ready;
  assign data_stall = data_req & ~data_ready;

  // mem_addr/mem_wdata/mem_wstrb double as the command registers, so the bus
  // stays stable for every REQ cycle regardless of what the pipeline does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_rdata <= '0;
      data_rdata <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Data wins: the M-stage instruction is older than the fetch.
          if (data_req) begin
            owner     <= 1'b1;
            mem_addr  <= data_addr;
            mem_wdata <= data_wdata;
            mem_wstrb <= data_wen;
            mem_wr    <= |data_wen;
            mem_req   <= 1'b1;
            state     <= REQ;
          end else if (inst_req) begin
            owner     <= 1'b0;
            mem_addr  <= inst_addr;
            mem_wstrb <= 4'b0000;
            mem_wr    <= 1'b0;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_addr_ok) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            if (mem_data_ok) begin
              if (!owner)               inst_rdata <= mem_rdata;
              else if (mem_wstrb == '0) data_rdata <= mem_rdata;
              inst_ready <= ~owner;
              data_ready <= owner;
              state      <= DONE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (mem_data_ok) begin
            // A write-ack carries no load data.
            if (!owner)               inst_rdata <= mem_rdata;
            else if (mem_wstrb == '0) data_rdata <= mem_rdata;
            inst_ready <= ~owner;
            data_ready <= owner;
            state      <= DONE;
          end
        end
        DONE: begin
          // Requests are not sampled here; the requester updates at this edge.
          inst_ready <= 1'b0;
          data_ready <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: slave model with programmable wait states,
// scoreboard of expected completions checked on every ready pulse.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready, inst_stall;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_ready, data_stall;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready), .inst_stall(inst_stall),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_ready(data_ready), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          fails = 0;
  logic [31:0] exp_inst = 32'h0;
  logic [31:0] exp_data = 32'h0;

  // slave controls
  int   addr_wait = 0;
  int   data_wait = 0;
  logic spurious  = 1'b0;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h2408_0001;
    return (a ^ 32'h5A5A_0000) + 32'd7;
  endfunction

  // Slave: drives handshakes at the falling edge so the DUT samples them cleanly.
  initial begin : slave
    int          acnt, dcnt;
    logic        pend;
    logic [31:0] s_addr;
    acnt = 0; dcnt = 0; pend = 1'b0; s_addr = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      if (rst) begin
        pend = 1'b0; acnt = 0;
      end else if (spurious) begin
        mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0; spurious = 1'b0;
      end else if (mem_req) begin
        if (acnt < addr_wait) acnt++;
        else begin
          mem_addr_ok = 1'b1; acnt = 0; s_addr = mem_addr;
          if (data_wait == 0) begin mem_data_ok = 1'b1; mem_rdata = mem_val(mem_addr); end
          else begin pend = 1'b1; dcnt = 0; end
        end
      end else if (pend) begin
        dcnt++;
        if (dcnt >= data_wait) begin
          mem_data_ok = 1'b1; mem_rdata = mem_val(s_addr); pend = 1'b0;
        end
      end
    end
  end

  // Scoreboard: every ready pulse must match the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && (inst_ready || data_ready)) begin
        tests_run++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: inst_ready=%0b data_ready=%0b with no pending expectation", inst_ready, data_ready);
        end else begin
          e = sb.pop_front();
          if (data_ready !== e.owner || inst_ready !== ~e.owner) begin
            fails++;
            $display("FAIL sb_owner: got inst_ready=%0b data_ready=%0b, expected owner %0b", inst_ready, data_ready, e.owner);
          end else if (!e.owner && inst_rdata !== e.data) begin
            fails++;
            $display("FAIL sb_inst_rdata: got %h expected %h", inst_rdata, e.data);
          end else if (e.owner && data_rdata !== e.data) begin
            fails++;
            $display("FAIL sb_data_rdata: got %h expected %h", data_rdata, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    inst_req = 1'b1; data_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tests_run++;
    if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_wstrb !== 4'h0) begin
      fails++; $display("FAIL reset_bus_ctl: req=%b wr=%b wstrb=%h expected 0", mem_req, mem_wr, mem_wstrb);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      fails++; $display("FAIL reset_bus_dat: addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    tests_run++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_rdata: inst=%h data=%h expected 0", inst_rdata, data_rdata);
    end
    tests_run++;
    if (inst_ready !== 1'b0 || data_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready: inst=%b data=%b expected 0", inst_ready, data_ready);
    end
    tests_run++;
    if (inst_stall !== 1'b1 || data_stall !== 1'b1) begin
      fails++; $display("FAIL reset_stall_hi: inst=%b data=%b expected 1", inst_stall, data_stall);
    end
    inst_req = 1'b0; data_req = 1'b0; #1;
    tests_run++;
    if (inst_stall !== 1'b0 || data_stall !== 1'b0) begin
      fails++; $display("FAIL reset_stall_lo: inst=%b data=%b expected 0", inst_stall, data_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch_zero_wait();
    int cyc, req_cyc, stall_cyc, rdy_cyc;
    logic [31:0] seen_addr;
    addr_wait = 0; data_wait = 0;
    @(negedge clk);
    inst_addr = 32'h1FC0_0000; inst_req = 1'b1;
    exp_inst = 32'h2408_0001; sb.push_back('{1'b0, 32'h2408_0001});
    cyc = 1; req_cyc = 0; stall_cyc = 0; rdy_cyc = 0; seen_addr = '0;
    for (int k = 0; k < 20 && rdy_cyc == 0; k++) begin
      #1;
      if (mem_req) begin req_cyc++; seen_addr = mem_addr; end
      if (inst_stall) stall_cyc++;
      if (inst_ready) begin rdy_cyc = cyc; inst_req = 1'b0; end
      @(negedge clk); cyc++;
    end
    tests_run++;
    if (rdy_cyc != 3) begin fails++; $display("FAIL fetch_latency: ready in cycle %0d expected 3", rdy_cyc); end
    tests_run++;
    if (req_cyc != 1 || seen_addr !== 32'h1FC0_0000) begin
      fails++; $display("FAIL fetch_mem_req: %0d cycles addr %h expected 1 cycle addr 1fc00000", req_cyc, seen_addr);
    end
    tests_run++;
    if (stall_cyc != 2) begin fails++; $display("FAIL fetch_stall: %0d cycles expected 2", stall_cyc); end
    #1;
    tests_run++;
    if (inst_ready !== 1'b0 || inst_rdata !== 32'h2408_0001) begin
      fails++; $display("FAIL fetch_hold: ready=%b rdata=%h expected 0/24080001", inst_ready, inst_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int cyc, dcyc, icyc, stall_bad;
    logic [31:0] first_addr;
    logic got_first;
    @(negedge clk);
    data_addr = 32'h8000_0010; data_wen = 4'b0000; data_req = 1'b1;
    inst_addr = 32'h1FC0_0010; inst_req = 1'b1;
    exp_data = mem_val(32'h8000_0010); sb.push_back('{1'b1, mem_val(32'h8000_0010)});
    exp_inst = mem_val(32'h1FC0_0010); sb.push_back('{1'b0, mem_val(32'h1FC0_0010)});
    cyc = 1; dcyc = 0; icyc = 0; stall_bad = 0; got_first = 1'b0; first_addr = '0;
    for (int k = 0; k < 40 && icyc == 0; k++) begin
      #1;
      if (mem_req && !got_first) begin first_addr = mem_addr; got_first = 1'b1; end
      if (inst_ready) begin icyc = cyc; inst_req = 1'b0; end
      else if (inst_stall !== 1'b1) stall_bad++;
      if (data_ready) begin dcyc = cyc; data_req = 1'b0; end
      @(negedge clk); cyc++;
    end
    tests_run++;
    if (first_addr !== 32'h8000_0010) begin fails++; $display("FAIL simul_first: addr %h expected 80000010", first_addr); end
    tests_run++;
    if (dcyc != 3 || icyc != 6) begin
      fails++; $display("FAIL simul_order: data_ready cycle %0d inst_ready cycle %0d expected 3 and 6", dcyc, icyc);
    end
    tests_run++;
    if (stall_bad != 0) begin fails++; $display("FAIL simul_stall: %0d low cycles expected 0", stall_bad); end
  endtask

  task automatic test_store_wait();
    int cyc, req_cyc, bad, pulses, rcyc;
    logic [31:0] old;
    addr_wait = 2; data_wait = 3;
    @(negedge clk);
    old = exp_data;
    data_addr = 32'h8000_0004; data_wdata = 32'hDEAD_BEEF; data_wen = 4'b0011; data_req = 1'b1;
    sb.push_back('{1'b1, old});
    cyc = 1; req_cyc = 0; bad = 0; pulses = 0; rcyc = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (mem_req) begin
        req_cyc++;
        if (mem_wr !== 1'b1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h8000_0004 || mem_wdata !== 32'hDEAD_BEEF) bad++;
      end
      if (data_ready) begin pulses++; rcyc = cyc; data_req = 1'b0; data_wen = 4'b0000; end
      @(negedge clk); cyc++;
    end
    tests_run++;
    if (req_cyc != 3 || bad != 0) begin
      fails++; $display("FAIL store_bus: %0d REQ cycles, %0d unstable, expected 3 and 0", req_cyc, bad);
    end
    tests_run++;
    if (pulses != 1 || rcyc != 8) begin
      fails++; $display("FAIL store_ready: %0d pulses at cycle %0d expected 1 at 8", pulses, rcyc);
    end
    tests_run++;
    if (data_rdata !== old) begin fails++; $display("FAIL store_rdata: %h expected %h", data_rdata, old); end
    addr_wait = 0; data_wait = 0;
  endtask

  task automatic test_spurious();
    int rdy, reqs;
    @(negedge clk); #1;
    spurious = 1'b1;
    rdy = 0; reqs = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (inst_ready || data_ready) rdy++;
      if (mem_req) reqs++;
    end
    tests_run++;
    if (rdy != 0 || reqs != 0) begin
      fails++; $display("FAIL spurious_activity: %0d ready, %0d req cycles expected 0", rdy, reqs);
    end
    tests_run++;
    if (inst_rdata !== exp_inst || data_rdata !== exp_data) begin
      fails++; $display("FAIL spurious_rdata: inst %h data %h expected %h %h", inst_rdata, data_rdata, exp_inst, exp_data);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rcyc;
    logic seen, inresp;
    addr_wait = 0; data_wait = 5;
    @(negedge clk);
    inst_addr = 32'h1FC0_0040; inst_req = 1'b1;
    seen = 1'b0; inresp = 1'b0;
    for (int k = 0; k < 20 && !inresp; k++) begin
      #1;
      if (mem_req) seen = 1'b1;
      else if (seen) inresp = 1'b1;
      if (!inresp) @(negedge clk);
    end
    tests_run++;
    if (!inresp) begin fails++; $display("FAIL rstmid_reach_resp: got %b expected 1", inresp); end
    rst = 1'b1; #1;
    tests_run++;
    if (mem_req !== 1'b0 || inst_ready !== 1'b0 || data_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs: req=%b iready=%b dready=%b expected 0", mem_req, inst_ready, data_ready);
    end
    inst_req = 1'b0;
    exp_inst = 32'h0; exp_data = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      fails++; $display("FAIL rstmid_rdata: inst %h data %h expected 0", inst_rdata, data_rdata);
    end
    data_wait = 0;
    @(negedge clk);
    inst_addr = 32'h1FC0_0080; inst_req = 1'b1;
    exp_inst = mem_val(32'h1FC0_0080); sb.push_back('{1'b0, mem_val(32'h1FC0_0080)});
    cyc = 1; rcyc = 0;
    for (int k = 0; k < 20 && rcyc == 0; k++) begin
      #1;
      if (inst_ready) begin rcyc = cyc; inst_req = 1'b0; end
      @(negedge clk); cyc++;
    end
    tests_run++;
    if (rcyc != 3) begin fails++; $display("FAIL rstmid_refetch: ready cycle %0d expected 3", rcyc); end
  endtask

  task automatic test_back_to_back();
    int cyc, prev, n, bad;
    addr_wait = 0; data_wait = 0;
    @(negedge clk);
    inst_addr = 32'h0040_0000; inst_req = 1'b1;
    exp_inst = mem_val(inst_addr); sb.push_back('{1'b0, mem_val(inst_addr)});
    cyc = 1; prev = 0; n = 0; bad = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      #1;
      if (inst_ready) begin
        n++;
        if (cyc - prev != 3) bad++;
        prev = cyc;
        if (n < 8) begin
          inst_addr = inst_addr + 32'd4;
          exp_inst = mem_val(inst_addr); sb.push_back('{1'b0, mem_val(inst_addr)});
        end else inst_req = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    tests_run++;
    if (n != 8) begin fails++; $display("FAIL b2b_count: %0d pulses expected 8", n); end
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL b2b_spacing: %0d gaps not equal to 3, expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    test_reset();
    test_fetch_zero_wait();
    test_simultaneous();
    test_store_wait();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin fails++; $display("FAIL sb_drain: %0d pending expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer that shares one memory port between the CPU's instruction fetch (F stage) and the data access (M stage). It serialises the two requesters onto a split-handshake bus (`req`/`addr_ok`/`data_ok`). It also generates the per-side stall signals that feed the hazard unit. It sits between the pipeline datapath (`PC`, `Mem_en`/`Mem_write_en`/`Mem_addr`/`Write_data`/`Read_data`) and the SRAM-like memory interface.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: reset, asynchronous, active-high
- `inst_req` in 1: fetch request; held high until `inst_ready`
- `inst_addr` in ADDR_W: fetch address; stable while `inst_req` is high
- `inst_rdata` out DATA_W: fetched word; valid with `inst_ready` and held until the next fetch completes
- `inst_ready` out 1: one-cycle pulse; fetch complete
- `inst_stall` out 1: `inst_req & ~inst_ready`
- `data_req` in 1: load/store request; held until `data_ready`
- `data_wen` in 4: byte write enables; `0000` means load
- `data_addr` in ADDR_W: data address
- `data_wdata` in DATA_W: store data
- `data_rdata` out DATA_W: load result; valid with `data_ready` and held until the next data completion
- `data_ready` out 1: one-cycle pulse; data access complete
- `data_stall` out 1: `data_req & ~data_ready`
- `mem_req` out 1: bus request
- `mem_wr` out 1: bus write
- `mem_wstrb` out 4: byte strobes
- `mem_addr` out ADDR_W: bus address
- `mem_wdata` out DATA_W: bus write data
- `mem_addr_ok` in 1: request accepted this cycle
- `mem_data_ok` in 1: response/write-ack this cycle
- `mem_rdata` in DATA_W: read data, valid with `mem_data_ok`

## Operation
- **Outstanding transactions:** one at a time. The FSM states are IDLE, REQ, RESP, DONE. A 1-bit `owner` register holds 0 = inst, 1 = data.
- **IDLE:**
  - If `data_req`: latch `data_addr`, `data_wdata` and `data_wen` into the command registers, set `owner=1`, go to REQ.
  - Else if `inst_req`: latch `inst_addr`, wstrb=0, set `owner=0`, go to REQ.
  - Data always wins, because the M-stage instruction is older. Starvation of fetch is impossible because the data side completes and advances.
- **REQ:**
  - `mem_req=1`. `mem_addr`, `mem_wdata` and `mem_wstrb` come from the command registers. `mem_wr = |wstrb`.
  - `mem_addr_ok & mem_data_ok` in the same cycle: capture `mem_rdata`, go to DONE.
  - `mem_addr_ok` alone: go to RESP.
  - Otherwise stay in REQ, holding all bus outputs stable.
- **RESP:** `mem_req=0`. On `mem_data_ok`, capture `mem_rdata` into `inst_rdata` or `data_rdata` according to `owner`, then go to DONE.
- **DONE:** pulse `inst_ready` or `data_ready` according to `owner`, then go to IDLE.
  - Requests are not sampled in DONE. The requester drops `req` or changes its address at the edge ending DONE.
- **Writes:** a write completes identically. `mem_data_ok` is the write-ack. `data_rdata` is not updated on a write.
- **Late requests:** a request raised while the other side is in flight waits in IDLE arbitration. Its stall stays high throughout.
- **Unexpected responses:** `mem_data_ok` in IDLE or DONE is ignored. `mem_addr_ok` outside REQ is ignored.

## Timing
- **Reset values:**
  - State IDLE, `owner=0`.
  - `mem_req`, `mem_wr`, `inst_ready`, `data_ready` = 0.
  - `mem_wstrb`, `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata` = 0.
  - Stalls follow their combinational definition.
- **Reset mid-transaction:** immediately return to IDLE and drop `mem_req`. The memory slave shares `rst`, so no stale `data_ok` is expected.
- **Minimum latency, request high to ready pulse:**
  - 3 cycles: IDLE, REQ with `addr_ok` and `data_ok`, DONE.
  - 4 cycles when `data_ok` arrives one cycle after `addr_ok`.
- **Back-to-back throughput:** a new transaction starts no sooner than the cycle after DONE, giving minimum 3 cycles per access.
- **Output registering:**
  - `mem_*` outputs are registered or decoded from state and registers only. No combinational path from `inst_*`/`data_*` inputs to `mem_*`.
  - `*_ready` are decoded from state and `owner`.
  - `*_stall` are combinational from `*_req` and `*_ready`.
- **Wait states:** unbounded waits on `addr_ok` and `data_ok` are legal. The FSM holds its state without limit.

## Test plan
- **Fetch only, zero-wait:** `inst_req=1`, `inst_addr=0x1FC0_0000`, slave asserts `addr_ok` and `data_ok` with `rdata=0x2408_0001` in the first REQ cycle.
  - → `mem_req` high exactly 1 cycle with that address.
  - → `inst_ready` pulses in the 3rd cycle, `inst_rdata=0x2408_0001`.
  - → `inst_stall` is high for 2 cycles.
- **Simultaneous requests:** `inst_req` and `data_req` (load, `0x8000_0010`) raised in the same cycle.
  - → Data is issued first and `data_ready` pulses.
  - → The fetch is issued on the next IDLE.
  - → `inst_stall` stays high until its own `inst_ready`.
- **Store with wait states:** `data_wen=0011`, `addr=0x8000_0004`, `wdata=0xDEAD_BEEF`. Slave delays `addr_ok` 2 cycles, then `data_ok` 3 cycles later.
  - → `mem_wr=1`, `mem_wstrb=0011`, address and data stable across all REQ cycles.
  - → `data_ready` pulses once.
  - → `data_rdata` is unchanged.
- **Reset mid-operation:** assert `rst` while in RESP.
  - → Same cycle: `mem_req=0`, no ready pulse.
  - → After release, a new fetch completes normally.
- **Spurious `mem_data_ok` in IDLE:**
  - → No ready pulse and `rdata` registers unchanged.
- **Back-to-back fetches:** `inst_req` held with the address advancing by 4 after each ready, 8 fetches, zero-wait slave.
  - → 8 ready pulses spaced exactly 3 cycles apart, with correct data for each.
